// File: rtl/bp_cce_pkg.sv
// Shared encodings for the mock coherence engine.
//   bp_cce_cmd_op_e     : LCE command opcode (SET_TAG / WRITEBACK)
//   bp_coh_state_e      : coherence state carried by SET_TAG (I/S/E/M)
//   bp_mock_cce_state_e : mock CCE transaction FSM states
package bp_cce_pkg;

  typedef enum logic {
    e_cmd_set_tag   = 1'b0,
    e_cmd_writeback = 1'b1
  } bp_cce_cmd_op_e;

  typedef enum logic [1:0] {
    e_coh_i = 2'd0,
    e_coh_s = 2'd1,
    e_coh_e = 2'd2,
    e_coh_m = 2'd3
  } bp_coh_state_e;

  typedef enum logic [2:0] {
    e_idle,
    e_wb_cmd,
    e_wb_resp,
    e_data_cmd,
    e_tag_cmd,
    e_wait_ack
  } bp_mock_cce_state_e;

endpackage

// File: rtl/bp_me_mock_cce_mem.sv
// Backing store for the mock CCE: els_p blocks of width_p bits.
//   clk_i / reset_n_i : clock, async active-low reset (clears every block)
//   w_v_i, w_idx_i, w_data_i : single synchronous write port
//   r_idx_i / r_data_o       : combinational read port
module bp_me_mock_cce_mem
  import bp_cce_pkg::*;
#(
  parameter int unsigned els_p   = 16,
  parameter int unsigned width_p = 64,
  parameter int unsigned idx_w_p = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               w_v_i,
  input  logic [idx_w_p-1:0] w_idx_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic [idx_w_p-1:0] r_idx_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];

  always_comb begin
    mem_d = mem_q;
    if (w_v_i) begin
      mem_d[w_idx_i] = w_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign r_data_o = mem_q[r_idx_i];

endmodule

// File: rtl/bp_me_mock_cce.sv
// Mock single-LCE coherence engine. Accepts one miss at a time, optionally
// runs a victim writeback, returns the block from internal memory, sets the
// tag (E for loads, M for stores) and waits for the coherence ack.
//   clk_i / reset_n_i            : clock, async active-low reset
//   req_*                        : miss request from the LCE
//   cmd_*                        : LCE command (WRITEBACK / SET_TAG)
//   data_cmd_*                   : block data returned to the LCE
//   data_resp_*                  : writeback data from the LCE
//   ack_v_i / ack_ready_o        : coherence ack
//   busy_o                       : transaction in flight
module bp_me_mock_cce
  import bp_cce_pkg::*;
#(
  parameter  int unsigned num_lce_p     = 2,
  parameter  int unsigned paddr_width_p = 22,
  parameter  int unsigned lce_assoc_p   = 8,
  parameter  int unsigned block_width_p = 64,
  parameter  int unsigned mem_els_p     = 16,
  localparam int unsigned lce_id_w      = $clog2(num_lce_p),
  localparam int unsigned way_w         = $clog2(lce_assoc_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic [lce_id_w-1:0]      req_lce_id_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic                     req_store_i,
  input  logic [way_w-1:0]         req_lru_way_i,
  input  logic                     req_lru_dirty_i,

  output logic                     cmd_v_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_op_o,
  output logic [lce_id_w-1:0]      cmd_lce_id_o,
  output logic [paddr_width_p-1:0] cmd_addr_o,
  output logic [way_w-1:0]         cmd_way_o,
  output logic [1:0]               cmd_state_o,

  output logic                     data_cmd_v_o,
  input  logic                     data_cmd_ready_i,
  output logic [lce_id_w-1:0]      data_cmd_lce_id_o,
  output logic [paddr_width_p-1:0] data_cmd_addr_o,
  output logic [way_w-1:0]         data_cmd_way_o,
  output logic [block_width_p-1:0] data_cmd_data_o,

  input  logic                     data_resp_v_i,
  output logic                     data_resp_ready_o,
  input  logic                     data_resp_null_i,
  input  logic [paddr_width_p-1:0] data_resp_addr_i,
  input  logic [block_width_p-1:0] data_resp_data_i,

  input  logic                     ack_v_i,
  output logic                     ack_ready_o,

  output logic                     busy_o
);

  localparam int unsigned offset_w = $clog2(block_width_p / 8);
  localparam int unsigned idx_w    = $clog2(mem_els_p);

  bp_mock_cce_state_e         state_q, state_d;
  logic [lce_id_w-1:0]        lce_q, lce_d;
  logic [paddr_width_p-1:0]   addr_q, addr_d;
  logic [way_w-1:0]           way_q, way_d;
  logic                       store_q, store_d;

  logic                       mem_w_v;
  logic [block_width_p-1:0]   mem_r_data;

  // Only the index field of the writeback address selects a block.
  logic unused_resp_addr;
  assign unused_resp_addr = ^data_resp_addr_i;

  always_comb begin
    state_d = state_q;
    lce_d   = lce_q;
    addr_d  = addr_q;
    way_d   = way_q;
    store_d = store_q;
    mem_w_v = 1'b0;

    unique case (state_q)
      e_idle: begin
        if (req_v_i) begin
          lce_d                 = req_lce_id_i;
          addr_d                = req_addr_i;
          addr_d[offset_w-1:0]  = '0;
          way_d                 = req_lru_way_i;
          store_d               = req_store_i;
          state_d               = req_lru_dirty_i ? e_wb_cmd : e_data_cmd;
        end
      end
      e_wb_cmd:   if (cmd_ready_i) state_d = e_wb_resp;
      e_wb_resp: begin
        if (data_resp_v_i) begin
          mem_w_v = ~data_resp_null_i;
          state_d = e_data_cmd;
        end
      end
      e_data_cmd: if (data_cmd_ready_i) state_d = e_tag_cmd;
      e_tag_cmd:  if (cmd_ready_i)      state_d = e_wait_ack;
      e_wait_ack: if (ack_v_i)          state_d = e_idle;
      default:    state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      lce_q   <= '0;
      addr_q  <= '0;
      way_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lce_q   <= lce_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      store_q <= store_d;
    end
  end

  // Outputs are pure functions of state and latched fields, so valids never
  // depend on the matching ready and fields hold steady under backpressure.
  always_comb begin
    req_ready_o       = (state_q == e_idle);
    cmd_v_o           = (state_q == e_wb_cmd) || (state_q == e_tag_cmd);
    cmd_op_o          = (state_q == e_wb_cmd) ? e_cmd_writeback : e_cmd_set_tag;
    cmd_state_o       = e_coh_i;
    if (state_q == e_tag_cmd) begin
      cmd_state_o = store_q ? e_coh_m : e_coh_e;
    end
    data_cmd_v_o      = (state_q == e_data_cmd);
    data_resp_ready_o = (state_q == e_wb_resp);
    ack_ready_o       = (state_q == e_wait_ack);
    busy_o            = (state_q != e_idle);
  end

  assign cmd_lce_id_o      = lce_q;
  assign cmd_addr_o        = addr_q;
  assign cmd_way_o         = way_q;
  assign data_cmd_lce_id_o = lce_q;
  assign data_cmd_addr_o   = addr_q;
  assign data_cmd_way_o    = way_q;
  assign data_cmd_data_o   = mem_r_data;

  bp_me_mock_cce_mem #(
    .els_p   (mem_els_p),
    .width_p (block_width_p),
    .idx_w_p (idx_w)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .w_v_i     (mem_w_v),
    .w_idx_i   (data_resp_addr_i[offset_w +: idx_w]),
    .w_data_i  (data_resp_data_i),
    .r_idx_i   (addr_q[offset_w +: idx_w]),
    .r_data_o  (mem_r_data)
  );

endmodule
